// File: rtl/aq_axi_sdma64_pkg.sv
// Shared types and AXI constants for the 64-bit streaming DMA write path.
package aq_axi_sdma64_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_WAIT_DATA,
        ST_AW,
        ST_W,
        ST_B,
        ST_FIN
    } state_t;

    localparam logic [2:0] SIZE_64    = 3'b011;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    localparam int         PAGE_BYTES = 4096;
    localparam int         BEAT_BYTES = 8;
    // A 4 KB page holds 512 64-bit beats
    localparam logic [9:0] PAGE_BEATS = 10'(PAGE_BYTES / BEAT_BYTES);

endpackage

// File: rtl/aq_axi_sdma64_wburst_calc.sv
// Burst length calculator: the smallest of MAX_BURST, the remaining beats
// and the beats left before the next 4 KB page boundary.
module aq_axi_sdma64_wburst_calc #(
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 24
) (
    input  logic [8:0]       page_off,
    input  logic [LEN_W-1:0] rem,
    output logic [9:0]       beats
);
    import aq_axi_sdma64_pkg::*;

    localparam logic [9:0] MAX_C = 10'(MAX_BURST);

    logic [9:0] page_left;
    logic [9:0] rem_c;

    // page_off is the beat index within the page, so page_left is 1..512
    assign page_left = PAGE_BEATS - {1'b0, page_off};
    // Anything beyond one page cannot matter for the minimum
    assign rem_c     = (rem > LEN_W'(PAGE_BEATS)) ? PAGE_BEATS : 10'(rem);

    // Three-way minimum
    always_comb begin
        beats = MAX_C;
        if (page_left < beats) beats = page_left;
        if (rem_c < beats)     beats = rem_c;
    end

endmodule

// File: rtl/aq_axi_sdma64_wburst.sv
// Write-side burst master: drains the FWFT FIFO into AXI4 INCR bursts,
// one burst outstanding, with per-command DONE/ERR status.
//
// state        | meaning
// ST_IDLE      | ready for a command
// ST_CALC      | size next burst (MAX_BURST / remaining / 4 KB page)
// ST_WAIT_DATA | wait until the FIFO holds the whole burst
// ST_AW        | address phase
// ST_W         | data phase, FIFO popped on each handshake
// ST_B         | wait write response, advance addr/rem
// ST_FIN       | one-cycle DONE/ERR report
module aq_axi_sdma64_wburst #(
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = 24
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [31:0]      CMD_ADDR,
    input  logic [LEN_W-1:0] CMD_LEN,
    output logic             DONE,
    output logic             ERR,
    output logic             FIFO_RDEN,
    input  logic [64:0]      FIFO_DO,
    input  logic             FIFO_EMPTY,
    input  logic [12:0]      FIFO_RDCOUNT,
    output logic [31:0]      M_AXI_AWADDR,
    output logic [7:0]       M_AXI_AWLEN,
    output logic [2:0]       M_AXI_AWSIZE,
    output logic [1:0]       M_AXI_AWBURST,
    output logic             M_AXI_AWVALID,
    input  logic             M_AXI_AWREADY,
    output logic [63:0]      M_AXI_WDATA,
    output logic [7:0]       M_AXI_WSTRB,
    output logic             M_AXI_WLAST,
    output logic             M_AXI_WVALID,
    input  logic             M_AXI_WREADY,
    input  logic [1:0]       M_AXI_BRESP,
    input  logic             M_AXI_BVALID,
    output logic             M_AXI_BREADY
);
    import aq_axi_sdma64_pkg::*;

    state_t           state;
    logic [31:0]      addr;
    logic [LEN_W-1:0] rem;
    logic [9:0]       beats;
    logic [9:0]       cnt;
    logic [9:0]       calc_beats;
    logic             err;

    logic             in_w;
    logic             w_fire;
    logic             last_beat;
    logic             final_beat;
    logic             b_err;

    aq_axi_sdma64_wburst_calc #(
        .MAX_BURST (MAX_BURST),
        .LEN_W     (LEN_W)
    ) u_calc (
        .page_off (addr[11:3]),
        .rem      (rem),
        .beats    (calc_beats)
    );

    assign in_w       = (state == ST_W);
    assign last_beat  = (cnt == beats - 10'd1);
    // Last beat of the last burst of the command carries the packet marker
    assign final_beat = last_beat && (rem == LEN_W'(beats));
    assign b_err      = err | (M_AXI_BRESP != RESP_OKAY);

    assign M_AXI_AWSIZE  = SIZE_64;
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_WSTRB   = 8'hFF;
    assign M_AXI_WVALID  = in_w & ~FIFO_EMPTY;
    assign M_AXI_WDATA   = in_w ? FIFO_DO[63:0] : 64'd0;
    assign M_AXI_WLAST   = in_w & last_beat;
    assign w_fire        = M_AXI_WVALID & M_AXI_WREADY;
    assign FIFO_RDEN     = w_fire;

    // Command sequencing FSM with registered handshake and status outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state         <= ST_IDLE;
            CMD_READY     <= 1'b0;
            DONE          <= 1'b0;
            ERR           <= 1'b0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_AWADDR  <= 32'd0;
            M_AXI_AWLEN   <= 8'd0;
            addr          <= 32'd0;
            rem           <= '0;
            beats         <= 10'd0;
            cnt           <= 10'd0;
            err           <= 1'b0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    CMD_READY <= 1'b1;
                    if (CMD_VALID && CMD_READY) begin
                        CMD_READY <= 1'b0;
                        addr      <= CMD_ADDR & 32'hFFFF_FFF8;
                        rem       <= CMD_LEN;
                        err       <= 1'b0;
                        if (CMD_LEN == '0) begin
                            DONE  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    beats        <= calc_beats;
                    M_AXI_AWLEN  <= 8'(calc_beats - 10'd1);
                    M_AXI_AWADDR <= addr;
                    cnt          <= 10'd0;
                    state        <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (FIFO_RDCOUNT >= 13'(beats)) begin
                        M_AXI_AWVALID <= 1'b1;
                        state         <= ST_AW;
                    end
                end
                ST_AW: begin
                    if (M_AXI_AWREADY) begin
                        M_AXI_AWVALID <= 1'b0;
                        state         <= ST_W;
                    end
                end
                ST_W: begin
                    if (w_fire) begin
                        cnt <= cnt + 10'd1;
                        if (FIFO_DO[64] != final_beat) err <= 1'b1;
                        if (last_beat) begin
                            M_AXI_BREADY <= 1'b1;
                            state        <= ST_B;
                        end
                    end
                end
                ST_B: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        err          <= b_err;
                        addr         <= addr + {19'd0, beats, 3'd0};
                        rem          <= rem - LEN_W'(beats);
                        if (rem == LEN_W'(beats)) begin
                            DONE  <= 1'b1;
                            ERR   <= b_err;
                            state <= ST_FIN;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_FIN: begin
                    CMD_READY <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aq_axi_sdma64_wburst.sv
// Directed bench for the DMA write burst master with a FIFO and AXI slave model.
module tb_aq_axi_sdma64_wburst;
    import aq_axi_sdma64_pkg::*;

    localparam int LEN_W = 24;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             CMD_VALID = 1'b0;
    logic             CMD_READY;
    logic [31:0]      CMD_ADDR = 32'd0;
    logic [LEN_W-1:0] CMD_LEN = '0;
    logic             DONE, ERR, FIFO_RDEN, FIFO_EMPTY;
    logic [64:0]      FIFO_DO;
    logic [12:0]      FIFO_RDCOUNT;
    logic [31:0]      M_AXI_AWADDR;
    logic [7:0]       M_AXI_AWLEN;
    logic [2:0]       M_AXI_AWSIZE;
    logic [1:0]       M_AXI_AWBURST;
    logic             M_AXI_AWVALID;
    logic             M_AXI_AWREADY = 1'b1;
    logic [63:0]      M_AXI_WDATA;
    logic [7:0]       M_AXI_WSTRB;
    logic             M_AXI_WLAST, M_AXI_WVALID;
    logic             M_AXI_WREADY = 1'b1;
    logic [1:0]       M_AXI_BRESP = 2'b00;
    logic             M_AXI_BVALID = 1'b0;
    logic             M_AXI_BREADY;

    int checks = 0;
    int fails  = 0;

    aq_axi_sdma64_wburst #(.MAX_BURST(16), .LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
        .DONE(DONE), .ERR(ERR),
        .FIFO_RDEN(FIFO_RDEN), .FIFO_DO(FIFO_DO),
        .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RDCOUNT(FIFO_RDCOUNT),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WVALID(M_AXI_WVALID),
        .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY)
    );

    always #5 CLK = ~CLK;

    // FWFT FIFO model; data word i is D000_0000_0000_0000 + i
    logic [64:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cnt_force = -1;
    assign FIFO_DO      = mem[rd_ptr[7:0]];
    assign FIFO_EMPTY   = (wr_ptr == rd_ptr);
    assign FIFO_RDCOUNT = (cnt_force >= 0) ? 13'(cnt_force) : 13'(wr_ptr - rd_ptr);

    // Optional W backpressure: WREADY toggles every cycle
    logic stall = 1'b0;
    always @(negedge CLK) M_AXI_WREADY = stall ? ~M_AXI_WREADY : 1'b1;

    // AXI slave and protocol monitor
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    int  w_total = 0, rden_cnt = 0, n_last = 0, err_burst = -1;
    int  bb = 0, wlast_err = 0, wdata_err = 0, order_err = 0, fixed_err = 0;
    logic aw_pend = 1'b0;
    always @(posedge CLK) begin
        if (FIFO_RDEN) begin
            rd_ptr   <= rd_ptr + 1;
            rden_cnt <= rden_cnt + 1;
        end
        if (!RST_N) begin
            M_AXI_BVALID <= 1'b0;
            bb           <= 0;
            aw_pend      <= 1'b0;
        end else begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_addr_q.push_back(M_AXI_AWADDR);
                aw_len_q.push_back(M_AXI_AWLEN);
                if (aw_pend) order_err <= order_err + 1;
                aw_pend <= 1'b1;
                if (M_AXI_AWSIZE !== 3'b011 || M_AXI_AWBURST !== 2'b01) fixed_err <= fixed_err + 1;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_total <= w_total + 1;
                if (!aw_pend) order_err <= order_err + 1;
                if (M_AXI_WDATA !== 64'hD000_0000_0000_0000 + 64'(w_total)) wdata_err <= wdata_err + 1;
                if (M_AXI_WLAST !== (bb == int'(aw_len_q[$]))) wlast_err <= wlast_err + 1;
                if (M_AXI_WSTRB !== 8'hFF) fixed_err <= fixed_err + 1;
                if (M_AXI_WLAST) begin
                    bb           <= 0;
                    aw_pend      <= 1'b0;
                    M_AXI_BVALID <= 1'b1;
                    M_AXI_BRESP  <= (n_last == err_burst) ? 2'b10 : 2'b00;
                    n_last       <= n_last + 1;
                end else begin
                    bb <= bb + 1;
                end
            end
            if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push_words(input int n, input int stray);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[7:0]] = {(i == n - 1) || (i == stray), 64'hD000_0000_0000_0000 + 64'(wr_ptr)};
            wr_ptr = wr_ptr + 1;
        end
    endtask

    // Returns on the falling edge right after the accepting clock edge
    task automatic start_cmd(input logic [31:0] a, input int len);
        int k;
        @(negedge CLK);
        CMD_ADDR  = a;
        CMD_LEN   = LEN_W'(len);
        CMD_VALID = 1'b1;
        for (k = 0; k < 50; k++) begin
            if (CMD_READY) break;
            @(negedge CLK);
        end
        checks++;
        if (k == 50) begin
            fails++;
            $display("FAIL cmd_accept: CMD_READY=%b after %0d cycles, required 1", CMD_READY, k);
        end
        @(negedge CLK);
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_done(output logic e);
        int k;
        for (k = 0; k < 3000; k++) begin
            if (DONE) break;
            @(negedge CLK);
        end
        checks++;
        if (DONE !== 1'b1) begin
            fails++;
            $display("FAIL done_timeout: DONE=%b after %0d cycles, required 1", DONE, k);
        end
        e = ERR;
        @(negedge CLK);
        checks++;
        if (DONE !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: DONE=%b one cycle later, required 0", DONE);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({CMD_READY, DONE, ERR, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, FIFO_RDEN, M_AXI_WLAST} !== 8'd0 ||
            M_AXI_AWADDR !== 32'd0 || M_AXI_AWLEN !== 8'd0) begin
            fails++;
            $display("FAIL reset_outputs: ctl=%b awaddr=%h awlen=%h, required all 0",
                     {CMD_READY, DONE, ERR, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, FIFO_RDEN, M_AXI_WLAST},
                     M_AXI_AWADDR, M_AXI_AWLEN);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (CMD_READY !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: CMD_READY=%b, required 1", CMD_READY);
        end
    endtask

    task automatic test_single();
        int ab = aw_addr_q.size();
        int rb = rden_cnt;
        int wl = wlast_err, wd = wdata_err, oe = order_err;
        logic [2:0] lat;
        logic e;
        push_words(16, -1);
        start_cmd(32'h0000_1000, 16);
        lat[2] = M_AXI_AWVALID;
        @(negedge CLK); lat[1] = M_AXI_AWVALID;
        @(negedge CLK); lat[0] = M_AXI_AWVALID;
        checks++;
        if (lat !== 3'b001) begin fails++; $display("FAIL single_latency: awvalid trace=%b, required 001", lat); end
        wait_done(e);
        checks++;
        if (e !== 1'b0) begin fails++; $display("FAIL single_err: ERR=%b, required 0", e); end
        checks++;
        if (aw_addr_q.size() - ab !== 1) begin fails++; $display("FAIL single_nburst: %0d bursts, required 1", aw_addr_q.size() - ab); end
        checks++;
        if (aw_addr_q[ab] !== 32'h1000 || aw_len_q[ab] !== 8'd15) begin
            fails++; $display("FAIL single_aw: addr=%h len=%0d, required 1000/15", aw_addr_q[ab], aw_len_q[ab]);
        end
        checks++;
        if (rden_cnt - rb !== 16) begin fails++; $display("FAIL single_rden: %0d pops, required 16", rden_cnt - rb); end
        checks++;
        if (wlast_err - wl !== 0 || wdata_err - wd !== 0 || order_err - oe !== 0) begin
            fails++; $display("FAIL single_wphase: wlast_err=%0d wdata_err=%0d order_err=%0d, required 0/0/0",
                              wlast_err - wl, wdata_err - wd, order_err - oe);
        end
    endtask

    task automatic test_4k_split();
        int ab = aw_addr_q.size();
        logic [31:0] ea [2] = '{32'h0FE0, 32'h1000};
        logic e;
        push_words(8, -1);
        start_cmd(32'h0000_0FE0, 8);
        wait_done(e);
        checks++;
        if (e !== 1'b0) begin fails++; $display("FAIL split_err: ERR=%b, required 0", e); end
        checks++;
        if (aw_addr_q.size() - ab !== 2) begin fails++; $display("FAIL split_nburst: %0d bursts, required 2", aw_addr_q.size() - ab); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (aw_addr_q[ab + i] !== ea[i] || aw_len_q[ab + i] !== 8'd3) begin
                fails++; $display("FAIL split_aw%0d: addr=%h len=%0d, required %h/3", i, aw_addr_q[ab + i], aw_len_q[ab + i], ea[i]);
            end
        end
    endtask

    task automatic test_multi_stall();
        int ab = aw_addr_q.size();
        int rb = rden_cnt, wl = wlast_err, wd = wdata_err;
        logic [31:0] ea [3] = '{32'h2000, 32'h2080, 32'h2100};
        logic [7:0]  el [3] = '{8'd15, 8'd15, 8'd7};
        logic e;
        stall = 1'b1;
        push_words(40, -1);
        start_cmd(32'h0000_2000, 40);
        wait_done(e);
        stall = 1'b0;
        checks++;
        if (e !== 1'b0) begin fails++; $display("FAIL multi_err: ERR=%b, required 0", e); end
        checks++;
        if (aw_addr_q.size() - ab !== 3) begin fails++; $display("FAIL multi_nburst: %0d bursts, required 3", aw_addr_q.size() - ab); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (aw_addr_q[ab + i] !== ea[i] || aw_len_q[ab + i] !== el[i]) begin
                fails++; $display("FAIL multi_aw%0d: addr=%h len=%0d, required %h/%0d", i, aw_addr_q[ab + i], aw_len_q[ab + i], ea[i], el[i]);
            end
        end
        checks++;
        if (rden_cnt - rb !== 40) begin fails++; $display("FAIL multi_rden: %0d pops, required 40", rden_cnt - rb); end
        checks++;
        if (wlast_err - wl !== 0 || wdata_err - wd !== 0) begin
            fails++; $display("FAIL multi_wphase: wlast_err=%0d wdata_err=%0d, required 0/0", wlast_err - wl, wdata_err - wd);
        end
    endtask

    task automatic test_marker();
        int rb = rden_cnt;
        logic e;
        push_words(8, 2);
        start_cmd(32'h0000_3000, 8);
        wait_done(e);
        checks++;
        if (e !== 1'b1) begin fails++; $display("FAIL marker_err: ERR=%b, required 1", e); end
        checks++;
        if (rden_cnt - rb !== 8) begin fails++; $display("FAIL marker_rden: %0d pops, required 8", rden_cnt - rb); end
    endtask

    task automatic test_bresp_err();
        int ab = aw_addr_q.size();
        int rb = rden_cnt;
        logic e;
        err_burst = n_last + 1;
        push_words(48, -1);
        start_cmd(32'h0000_4000, 48);
        wait_done(e);
        err_burst = -1;
        checks++;
        if (e !== 1'b1) begin fails++; $display("FAIL bresp_err: ERR=%b, required 1", e); end
        checks++;
        if (aw_addr_q.size() - ab !== 3 || aw_addr_q[ab + 2] !== 32'h4100) begin
            fails++; $display("FAIL bresp_bursts: %0d bursts last addr=%h, required 3/4100", aw_addr_q.size() - ab, aw_addr_q[ab + 2]);
        end
        checks++;
        if (rden_cnt - rb !== 48) begin fails++; $display("FAIL bresp_rden: %0d pops, required 48", rden_cnt - rb); end
        ab = aw_addr_q.size();
        push_words(4, -1);
        start_cmd(32'h0000_5000, 4);
        wait_done(e);
        checks++;
        if (e !== 1'b0) begin fails++; $display("FAIL clean_after_err: ERR=%b, required 0", e); end
        checks++;
        if (aw_addr_q[ab] !== 32'h5000 || aw_len_q[ab] !== 8'd3) begin
            fails++; $display("FAIL clean_aw: addr=%h len=%0d, required 5000/3", aw_addr_q[ab], aw_len_q[ab]);
        end
    endtask

    task automatic test_zero_and_unaligned();
        int ab = aw_addr_q.size();
        int rb = rden_cnt;
        logic e;
        start_cmd(32'h0000_8000, 0);
        wait_done(e);
        checks++;
        if (e !== 1'b0 || aw_addr_q.size() != ab || rden_cnt != rb) begin
            fails++; $display("FAIL zero_len: ERR=%b bursts=%0d pops=%0d, required 0/0/0", e, aw_addr_q.size() - ab, rden_cnt - rb);
        end
        push_words(2, -1);
        start_cmd(32'h0000_6007, 2);
        wait_done(e);
        checks++;
        if (e !== 1'b0 || aw_addr_q[ab] !== 32'h6000 || aw_len_q[ab] !== 8'd1) begin
            fails++; $display("FAIL unaligned: ERR=%b addr=%h len=%0d, required 0/6000/1", e, aw_addr_q[ab], aw_len_q[ab]);
        end
    endtask

    task automatic test_rdcount_reset();
        int hi = 0;
        int k;
        cnt_force = 5;
        push_words(16, -1);
        start_cmd(32'h0000_7000, 16);
        repeat (15) begin if (M_AXI_AWVALID) hi++; @(negedge CLK); end
        cnt_force = 15;
        repeat (10) begin if (M_AXI_AWVALID) hi++; @(negedge CLK); end
        checks++;
        if (hi !== 0) begin fails++; $display("FAIL rdcount_hold: AWVALID high %0d cycles, required 0", hi); end
        cnt_force = 16;
        for (k = 0; k < 10; k++) begin
            if (M_AXI_AWVALID) break;
            @(negedge CLK);
        end
        checks++;
        if (M_AXI_AWVALID !== 1'b1) begin fails++; $display("FAIL rdcount_go: AWVALID=%b, required 1", M_AXI_AWVALID); end
        cnt_force = -1;
        for (k = 0; k < 10; k++) begin
            if (M_AXI_WVALID) break;
            @(negedge CLK);
        end
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (M_AXI_WVALID !== 1'b1) begin fails++; $display("FAIL midw_active: WVALID=%b, required 1", M_AXI_WVALID); end
        RST_N = 1'b0;
        @(negedge CLK);
        checks++;
        if ({CMD_READY, DONE, ERR, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, FIFO_RDEN, M_AXI_WLAST} !== 8'd0 ||
            M_AXI_AWADDR !== 32'd0 || M_AXI_AWLEN !== 8'd0 || dut.state !== ST_IDLE) begin
            fails++;
            $display("FAIL midw_reset: ctl=%b awaddr=%h awlen=%h state=%0d, required all 0 and IDLE",
                     {CMD_READY, DONE, ERR, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, FIFO_RDEN, M_AXI_WLAST},
                     M_AXI_AWADDR, M_AXI_AWLEN, dut.state);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (CMD_READY !== 1'b1) begin fails++; $display("FAIL midw_ready: CMD_READY=%b, required 1", CMD_READY); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_4k_split();
        test_multi_stall();
        test_marker();
        test_bresp_err();
        test_zero_and_unaligned();
        checks++;
        if (fixed_err !== 0 || order_err !== 0) begin
            fails++; $display("FAIL fixed_fields: fixed_err=%0d order_err=%0d, required 0/0", fixed_err, order_err);
        end
        test_rdcount_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/aq_axi_sdma64_wburst.md
Name: aq_axi_sdma64_wburst

Overview:
Write-side burst master for the 64-bit streaming DMA. Drains the read side of the 65-bit first-word-fall-through sync FIFO (bit 64 = end-of-packet marker, bits 63:0 = data) and issues AXI4 INCR write bursts to memory for one command at a time. It splits each command at MAX_BURST beats and at 4 KB boundaries, keeps one burst outstanding, and reports completion and error status per command.

Parameters:
MAX_BURST, 16, max beats per AXI burst (1..256, power of two)
LEN_W, 24, width of the command length field, in beats

Ports:
CLK  in  1  single clock, also the FIFO read clock
RST_N  in  1  reset
CMD_VALID  in  1  command request
CMD_READY  out  1  command accepted when VALID&READY
CMD_ADDR  in  32  start byte address, 8-byte aligned (bits 2:0 ignored)
CMD_LEN  in  LEN_W  beat count; 0 = no-op
DONE  out  1  one-cycle pulse at command completion
ERR  out  1  valid with DONE: BRESP error or marker mismatch
FIFO_RDEN  out  1  pop the FIFO
FIFO_DO  in  65  FWFT head word
FIFO_EMPTY  in  1  FIFO empty
FIFO_RDCOUNT  in  13  FIFO occupancy, in words
M_AXI_AWADDR  out  32;  M_AXI_AWLEN  out  8;  M_AXI_AWSIZE  out  3 (fixed 3'b011);  M_AXI_AWBURST  out  2 (fixed 2'b01)
M_AXI_AWVALID  out  1;  M_AXI_AWREADY  in  1
M_AXI_WDATA  out  64;  M_AXI_WSTRB  out  8 (fixed 8'hFF);  M_AXI_WLAST  out  1;  M_AXI_WVALID  out  1;  M_AXI_WREADY  in  1
M_AXI_BRESP  in  2;  M_AXI_BVALID  in  1;  M_AXI_BREADY  out  1

Behaviour:
- Reset: RST_N is synchronous and active-low; the block has one clock, CLK. Reset forces IDLE, CMD_READY=0, DONE=0, ERR=0, AWVALID=0, WVALID=0, BREADY=0, FIFO_RDEN=0, AWADDR=0, AWLEN=0, all counters 0. Reset mid-burst abandons the transfer; the FIFO is not flushed by this block.
- States: IDLE -> CALC -> WAIT_DATA -> AW -> W -> B -> (CALC | FIN) -> IDLE.
- IDLE: CMD_READY=1. On VALID&READY, latch addr={CMD_ADDR[31:3],3'b0}, rem=CMD_LEN, clear err; go to CALC. If CMD_LEN=0, go directly to FIN.
- CALC: beats = min(MAX_BURST, rem, (4096 - addr[11:0]) >> 3); register it and set AWLEN = beats-1.
- WAIT_DATA: advance when FIFO_RDCOUNT >= beats, so W never stalls on an empty FIFO.
- AW: AWVALID=1 until AWREADY; AWADDR and AWLEN are held stable while AWVALID is asserted.
- W: WVALID = ~FIFO_EMPTY; WDATA = FIFO_DO[63:0] combinationally; FIFO_RDEN = WVALID & WREADY. The beat counter increments on each handshake. WLAST = (count == beats-1). On the last handshake go to B.
- Marker check on each W handshake: FIFO_DO[64] must be 1 exactly on the final beat of the whole command (rem reaches 0); any other beat with 1, or a final beat with 0, sets err. Data is still written.
- B: BREADY=1; on BVALID, set err if BRESP != 2'b00. Then addr += beats<<3 (32-bit wrap, no carry out), rem -= beats. Go to CALC if rem != 0, else FIN.
- FIN: DONE=1 and ERR=err for exactly one cycle; CMD_READY=0; go to IDLE.
- Latency: CMD accept to AWVALID is 3 cycles minimum (CALC, WAIT_DATA, AW), given data is present.
- Ordering: at most one burst is outstanding; AW is always issued before W, with no W-before-AW.

Decomposition:
- Package aq_axi_sdma64_pkg: state enum; AXI constants (SIZE_64=3'b011, BURST_INCR=2'b01, RESP_OKAY=2'b00); 4 KB page constant.
- One natural sub-module, aq_axi_sdma64_wburst_calc: combinational burst-length and 4 KB-split calculator (addr, rem -> beats).

Test Plan:
- CMD_ADDR=0x1000, CMD_LEN=16, FIFO preloaded with 16 words (marker on word 15), always-ready slave -> one burst with AWADDR=0x1000, AWLEN=15, WLAST on beat 16; DONE with ERR=0.
- CMD_ADDR=0x0FE0, CMD_LEN=8 -> two bursts: AWADDR=0x0FE0 with AWLEN=3, then AWADDR=0x1000 with AWLEN=3.
- CMD_LEN=40, MAX_BURST=16 -> bursts of AWLEN 15, 15, 7; exactly 40 FIFO_RDEN pulses.
- Marker set on beat 3 of an 8-beat command -> all 8 beats written; DONE with ERR=1.
- BRESP=2'b10 on the second of three bursts -> all bursts complete; ERR=1. Next clean command reports ERR=0.
- RDCOUNT held at 5 with beats=16 -> AWVALID stays 0 until RDCOUNT reaches 16. Then assert RST_N=0 during W -> next cycle all outputs are 0, state IDLE, CMD_READY=1 after release.
